// File: rtl/divider_sched_pkg.sv
// Shared definitions for the divider scheduler: FSM encoding, watchdog margin
// and the quotient pattern returned on divide-by-zero.
package divider_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int WATCHDOG_MARGIN = 3;

    // Every quotient bit is set when the divisor is zero.
    localparam logic DBZ_QUOTIENT_BIT = 1'b1;

    // WATCHDOG_LIMIT for an N-bit divider.
    function automatic int watchdog_limit(input int n);
        return n + WATCHDOG_MARGIN;
    endfunction

endpackage

// File: rtl/divider_scheduler_if.sv
// Requester-side bundle of the divider scheduler.
// Handshake: a requester holds i_request and its operands until its o_grant pulse; o_done pulses once when the result is valid.
interface divider_scheduler_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic [M-1:0]            i_request;
    logic [M*N-1:0]          i_dividend;
    logic [M*N-1:0]          i_divisor;
    logic [M-1:0]            o_grant;
    logic [M-1:0]            o_done;
    logic [N-1:0]            o_quotient;
    logic [N-1:0]            o_remainder;
    logic                    o_divide_by_zero;
    logic                    o_error;
    logic                    o_busy;
    divider_sched_pkg::state_t dbg_state;

    modport master (
        output i_request, i_dividend, i_divisor,
        input  o_grant, o_done, o_quotient, o_remainder,
        input  o_divide_by_zero, o_error, o_busy, dbg_state
    );

    modport slave (
        input  i_request, i_dividend, i_divisor,
        output o_grant, o_done, o_quotient, o_remainder,
        output o_divide_by_zero, o_error, o_busy, dbg_state
    );

endinterface

// File: rtl/divider_scheduler_arbiter.sv
// Round-robin arbiter: searches from last_i+1 upward, wrapping modulo M,
// and returns the first requester found as a one-hot grant plus its index.
module round_robin_arbiter #(
    parameter int M = 4
) (
    input  logic [M-1:0]         req_i,
    input  logic [$clog2(M)-1:0] last_i,
    output logic [M-1:0]         grant_o,
    output logic [$clog2(M)-1:0] index_o
);
    localparam int IW = $clog2(M);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        grant_o = '0;
        index_o = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 1; i <= M; i++) begin
            cand = IW'((int'(last_i) + i) % M);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                index_o       = cand;
            end
        end
    end

endmodule

// File: rtl/divider_scheduler_divider.sv
// N-bit restoring divider, one quotient bit per cycle. The first bit is
// resolved on the start edge, so finished pulses N-1 edges after start is sampled.
module iterative_divider #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic         finished_o,
    output logic [N-1:0] quotient_o,
    output logic [N-1:0] remainder_o
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0] rem_q, quo_q;
    logic [CW-1:0] cnt_q;
    logic         running_q, finished_q;

    logic [N-1:0] src_rem, src_quo, step_rem, step_quo;
    logic [N:0]   shifted;
    logic         fits;

    always_comb begin
        src_rem  = start_i ? '0 : rem_q;
        src_quo  = start_i ? dividend_i : quo_q;
        shifted  = {src_rem, src_quo[N-1]};
        fits     = shifted >= {1'b0, divisor_i};
        // The partial remainder stays below the divisor, so N bits suffice.
        step_rem = fits ? (shifted[N-1:0] - divisor_i) : shifted[N-1:0];
        step_quo = {src_quo[N-2:0], fits};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            running_q  <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            finished_q <= 1'b0;
            if (start_i) begin
                rem_q     <= step_rem;
                quo_q     <= step_quo;
                cnt_q     <= CW'(N - 1);
                running_q <= 1'b1;
            end else if (running_q) begin
                rem_q <= step_rem;
                quo_q <= step_quo;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    running_q  <= 1'b0;
                    finished_q <= 1'b1;
                end
            end
        end
    end

    assign finished_o  = finished_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/divider_scheduler.sv
// Shares one iterative divider between M requesters: round-robin capture,
// divide-by-zero bypass, watchdog abort and one-cycle done pulse to the winner.
module divider_scheduler
    import divider_sched_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 4
) (
    input logic                i_clock,
    input logic                i_reset,
    divider_scheduler_if.slave bus
);
    localparam int IW       = $clog2(M);
    localparam int WD_LIMIT = watchdog_limit(N);
    localparam int WW       = $clog2(WD_LIMIT + 1);

    state_t        state_q, state_d;
    logic [N-1:0]  dividend_hold_q, dividend_hold_d;
    logic [N-1:0]  divisor_hold_q, divisor_hold_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic [IW-1:0] winner_q, winner_d;
    logic [IW-1:0] last_served_q, last_served_d;
    logic [M-1:0]  grant_q, grant_d;
    logic [M-1:0]  done_q, done_d;
    logic          dbz_q, dbz_d;
    logic          err_q, err_d;
    logic [WW-1:0] wd_q, wd_d;

    logic [M-1:0]  arb_grant;
    logic [IW-1:0] arb_index;
    logic [M-1:0]  winner_onehot;
    logic          div_start, div_abort, div_rst, div_finished;
    logic [N-1:0]  div_quotient, div_remainder;

    round_robin_arbiter #(.M(M)) u_arbiter (
        .req_i   (bus.i_request),
        .last_i  (last_served_q),
        .grant_o (arb_grant),
        .index_o (arb_index)
    );

    iterative_divider #(.N(N)) u_divider (
        .clk_i       (i_clock),
        .rst_i       (div_rst),
        .start_i     (div_start),
        .dividend_i  (dividend_hold_q),
        .divisor_i   (divisor_hold_q),
        .finished_o  (div_finished),
        .quotient_o  (div_quotient),
        .remainder_o (div_remainder)
    );

    assign div_rst       = i_reset | div_abort;
    assign winner_onehot = {{(M-1){1'b0}}, 1'b1} << winner_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q         <= S_IDLE;
            dividend_hold_q <= '0;
            divisor_hold_q  <= '0;
            quotient_q      <= '0;
            remainder_q     <= '0;
            winner_q        <= '0;
            last_served_q   <= IW'(M - 1);
            grant_q         <= '0;
            done_q          <= '0;
            dbz_q           <= 1'b0;
            err_q           <= 1'b0;
            wd_q            <= '0;
        end else begin
            state_q         <= state_d;
            dividend_hold_q <= dividend_hold_d;
            divisor_hold_q  <= divisor_hold_d;
            quotient_q      <= quotient_d;
            remainder_q     <= remainder_d;
            winner_q        <= winner_d;
            last_served_q   <= last_served_d;
            grant_q         <= grant_d;
            done_q          <= done_d;
            dbz_q           <= dbz_d;
            err_q           <= err_d;
            wd_q            <= wd_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        dividend_hold_d = dividend_hold_q;
        divisor_hold_d  = divisor_hold_q;
        quotient_d      = quotient_q;
        remainder_d     = remainder_q;
        winner_d        = winner_q;
        last_served_d   = last_served_q;
        dbz_d           = dbz_q;
        err_d           = err_q;
        wd_d            = wd_q;
        grant_d         = '0;
        done_d          = '0;
        div_start       = 1'b0;
        div_abort       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|bus.i_request) begin
                    dividend_hold_d = bus.i_dividend[arb_index*N +: N];
                    divisor_hold_d  = bus.i_divisor[arb_index*N +: N];
                    winner_d        = arb_index;
                    last_served_d   = arb_index;
                    grant_d         = arb_grant;
                    state_d         = S_START;
                end
            end
            S_START: begin
                // A zero divisor passes through WAIT without starting the
                // divider, which lands its done two cycles after the grant.
                div_start = (divisor_hold_q != '0);
                wd_d      = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (divisor_hold_q == '0) begin
                    quotient_d  = {N{DBZ_QUOTIENT_BIT}};
                    remainder_d = dividend_hold_q;
                    dbz_d       = 1'b1;
                    err_d       = 1'b0;
                    done_d      = winner_onehot;
                    state_d     = S_DONE;
                end else if (div_finished) begin
                    quotient_d  = div_quotient;
                    remainder_d = div_remainder;
                    dbz_d       = 1'b0;
                    err_d       = 1'b0;
                    done_d      = winner_onehot;
                    state_d     = S_DONE;
                end else if (wd_q == WW'(WD_LIMIT)) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                    err_d       = 1'b1;
                    done_d      = winner_onehot;
                    div_abort   = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_grant          = grant_q;
    assign bus.o_done           = done_q;
    assign bus.o_quotient       = quotient_q;
    assign bus.o_remainder      = remainder_q;
    assign bus.o_divide_by_zero = dbz_q;
    assign bus.o_error          = err_q;
    assign bus.o_busy           = (state_q != S_IDLE);
    assign bus.dbg_state        = state_q;

endmodule
